cabac_writeout: RTL and testbench
=================================

CABAC_WRITEOUT -- requirements
Module: cabac_writeout

Interface
REQ-001: clk  input  1  single clock; every register updates on its rising edge.
REQ-002: rst  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-003: bin_valid  input  1  a renormalised bin result is presented.
REQ-004: bin_ready  output  1  the block can accept a bin; high only in IDLE.
REQ-005: num_bits  input  3  renormalisation shift for the bin (0..7).
REQ-006: low_in  input  32  encoder low register after the renormalisation shift.
REQ-007: low_out  output  32  low register after lead-byte removal; registered.
REQ-008: low_valid  output  1  one-cycle pulse marking low_out updated.
REQ-009: bits_left  output  6  signed bit-budget counter; registered.
REQ-010: byte_valid / byte_ready / byte_data  output / input / output  1 / 1 / 8  output byte stream; a byte transfers when valid and ready are high in the same cycle.
REQ-011: flush_req  input  1  end-of-slice flush request; honoured only in IDLE.
REQ-012: flush_carry  input  1  carry from the final low, added during the flush.
REQ-013: flush_done  output  1  one-cycle pulse when the flush completes.

Function
REQ-014: A bin is accepted when bin_valid and bin_ready are both high; bl_next = bits_left - num_bits.
REQ-015: If bl_next >= 12 on an accepted bin:
- bits_left is set to bl_next;
- low_out is set to low_in;
- no lead byte is produced.
REQ-016: If bl_next < 12 on an accepted bin, sh = 24 - bl_next and:
- lead[8:0] = low_in[sh+8:sh];
- low_out = low_in & (0xFFFFFFFF >> (bl_next+8));
- bits_left = bl_next + 8.
REQ-017: low_valid pulses in the cycle after every accepted bin, so latency is 1 cycle.
REQ-018: If lead == 9'h0FF: num_buffered increments, no byte is emitted, and the state stays IDLE.
REQ-019: If lead != 9'h0FF and num_buffered == 0:
- buffered_byte is set to lead[7:0];
- num_buffered is set to 1;
- no byte is emitted.
REQ-020: If lead != 9'h0FF and num_buffered > 0:
- carry = lead[8];
- the state goes to EMIT_BUF with emit value buffered_byte + carry, taken mod 256;
- run value = (0xFF + carry) & 0xFF, run count = num_buffered - 1;
- buffered_byte is set to lead[7:0] and num_buffered to 1.
REQ-021: States are IDLE, EMIT_BUF, EMIT_RUN and DONE.
REQ-022: EMIT_BUF:
- byte_valid is high with the emit value;
- on handshake, go to EMIT_RUN if run count > 0, otherwise to IDLE.
REQ-023: EMIT_RUN:
- byte_valid is high with the run value;
- each handshake decrements run count;
- after the last handshake (run count reaches 0), go to IDLE, or to DONE when flushing.
REQ-024: byte_data and byte_valid hold stable while byte_ready is low, and no byte is dropped or duplicated.
REQ-025: flush_req in IDLE, with no bin accepted in the same cycle, starts a flush:
- if num_buffered == 0, go directly to DONE;
- otherwise go to EMIT_BUF with emit value buffered_byte + flush_carry;
- run value = flush_carry ? 0x00 : 0xFF, run count = num_buffered - 1;
- after the last byte, go to DONE.
REQ-026: If bin_valid and flush_req are both high in IDLE, the bin takes priority; flush_req is ignored that cycle.
REQ-027: DONE pulses flush_done for one cycle, clears num_buffered and buffered_byte to 0, sets bits_left to 23, and returns to IDLE.
REQ-028: num_buffered is 16 bits wide; the upstream source guarantees it never exceeds 65534, and the block does not check this.
REQ-029: By the range guarantee, one accepted bin produces at most one lead byte (bits_left is always >= 12 in IDLE).

Reset
REQ-030: rst takes effect in the same cycle, including mid-emission, and any pending bytes are discarded. After reset:
- state = IDLE;
- bits_left = 23;
- num_buffered = 0;
- buffered_byte = 0;
- low_out = 0;
- low_valid, byte_valid, flush_done = 0;
- bin_ready = 1.

Verification
REQ-031: From reset, accept num_bits=7 -> bits_left=16, low_valid pulses, no byte; then num_bits=5 -> bl_next=11, lead taken from low_in[21:13], bits_left=19.
REQ-032: Three bins give leads 0x012, 0x0FF, 0x0FF -> no bytes; then lead 0x034 -> bytes 0x12, 0xFF, 0xFF in order; buffered_byte=0x34, num_buffered=1.
REQ-033: buffered_byte=0x7F with two outstanding 0xFF, then lead 0x105 -> bytes 0x80, 0x00, 0x00; buffered_byte=0x05.
REQ-034: Hold byte_ready low for 5 cycles during EMIT_RUN -> byte_data stable, bin_ready=0, and the sequence resumes intact.
REQ-035: flush_req with flush_carry=1, buffered_byte=0xFF, num_buffered=2 -> bytes 0x00, 0x00, then flush_done pulse, and bits_left returns to 23.
REQ-036: rst asserted mid-EMIT_RUN -> next cycle byte_valid=0, bin_ready=1, bits_left=23.

Source files
------------

// File: rtl/cabac_writeout_if.sv
// Bundle of the bin, low-register, byte-stream and flush signals of the CABAC write-out stage.
interface cabac_writeout_if;
    logic              bin_valid;
    logic              bin_ready;
    logic [2:0]        num_bits;
    logic [31:0]       low_in;
    logic [31:0]       low_out;
    logic              low_valid;
    logic signed [5:0] bits_left;
    logic              byte_valid;
    logic              byte_ready;
    logic [7:0]        byte_data;
    logic              flush_req;
    logic              flush_carry;
    logic              flush_done;

    modport master (
        output bin_valid, num_bits, low_in, byte_ready, flush_req, flush_carry,
        input  bin_ready, low_out, low_valid, bits_left, byte_valid, byte_data, flush_done
    );

    modport slave (
        input  bin_valid, num_bits, low_in, byte_ready, flush_req, flush_carry,
        output bin_ready, low_out, low_valid, bits_left, byte_valid, byte_data, flush_done
    );
endinterface

// File: rtl/cabac_writeout.sv
// CABAC byte write-out: strips lead bytes from the encoder low register, holds 0xFF runs
// until the carry is resolved, then streams the resolved bytes; also handles end-of-slice flush.
module cabac_writeout (
    input  logic           clk,
    input  logic           rst,
    cabac_writeout_if.slave bus
);
    typedef enum logic [1:0] {IDLE, EMIT_BUF, EMIT_RUN, DONE} state_t;

    state_t            state, state_nxt;
    logic signed [5:0] bl_p1, bl_nxt;
    logic [31:0]       low_p1, low_nxt;
    logic              vld_p1, vld_nxt;
    logic [15:0]       nbuf, nbuf_nxt;
    logic [7:0]        bbyte, bbyte_nxt;
    logic [7:0]        emit_val, emit_nxt;
    logic [7:0]        run_val, run_val_nxt;
    logic [15:0]       run_cnt, run_cnt_nxt;
    logic              flushing, flushing_nxt;

    logic signed [6:0] bl_sub;
    logic [8:0]        lead;
    logic              accept;

    // Nine bits (carry + byte) sitting just above the bits still owed to the budget.
    function automatic logic [8:0] lead_of(input logic [31:0] low, input logic signed [6:0] bl);
        logic [4:0] sh;
        sh = 5'(7'sd24 - bl);
        return 9'(low >> sh);
    endfunction

    function automatic logic [31:0] strip_lead(input logic [31:0] low, input logic signed [6:0] bl);
        logic [4:0] keep;
        keep = 5'(bl + 7'sd8);
        return low & (32'hFFFF_FFFF >> keep);
    endfunction

    assign bl_sub = $signed({bl_p1[5], bl_p1}) - $signed({4'b0000, bus.num_bits});
    assign lead   = lead_of(bus.low_in, bl_sub);
    assign accept = bus.bin_valid && (state == IDLE);

    always_comb begin
        state_nxt    = state;
        bl_nxt       = bl_p1;
        low_nxt      = low_p1;
        vld_nxt      = 1'b0;
        nbuf_nxt     = nbuf;
        bbyte_nxt    = bbyte;
        emit_nxt     = emit_val;
        run_val_nxt  = run_val;
        run_cnt_nxt  = run_cnt;
        flushing_nxt = flushing;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    vld_nxt = 1'b1;
                    if (bl_sub >= 7'sd12) begin
                        bl_nxt  = bl_sub[5:0];
                        low_nxt = bus.low_in;
                    end else begin
                        bl_nxt  = bl_sub[5:0] + 6'sd8;
                        low_nxt = strip_lead(bus.low_in, bl_sub);
                        if (lead == 9'h0FF) begin
                            nbuf_nxt = nbuf + 16'd1;
                        end else if (nbuf == 16'd0) begin
                            bbyte_nxt = lead[7:0];
                            nbuf_nxt  = 16'd1;
                        end else begin
                            // The carry resolves the held byte and turns every pending 0xFF into 0x00.
                            emit_nxt    = bbyte + {7'b0, lead[8]};
                            run_val_nxt = lead[8] ? 8'h00 : 8'hFF;
                            run_cnt_nxt = nbuf - 16'd1;
                            bbyte_nxt   = lead[7:0];
                            nbuf_nxt    = 16'd1;
                            state_nxt   = EMIT_BUF;
                        end
                    end
                end else if (bus.flush_req) begin
                    flushing_nxt = 1'b1;
                    if (nbuf == 16'd0) begin
                        state_nxt = DONE;
                    end else begin
                        emit_nxt    = bbyte + {7'b0, bus.flush_carry};
                        run_val_nxt = bus.flush_carry ? 8'h00 : 8'hFF;
                        run_cnt_nxt = nbuf - 16'd1;
                        state_nxt   = EMIT_BUF;
                    end
                end
            end
            EMIT_BUF: begin
                if (bus.byte_ready) begin
                    if (run_cnt != 16'd0) state_nxt = EMIT_RUN;
                    else if (flushing)    state_nxt = DONE;
                    else                  state_nxt = IDLE;
                end
            end
            EMIT_RUN: begin
                if (bus.byte_ready) begin
                    run_cnt_nxt = run_cnt - 16'd1;
                    if (run_cnt == 16'd1) state_nxt = flushing ? DONE : IDLE;
                end
            end
            DONE: begin
                nbuf_nxt     = 16'd0;
                bbyte_nxt    = 8'h00;
                bl_nxt       = 6'sd23;
                flushing_nxt = 1'b0;
                state_nxt    = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Stage p1: registered low/budget outputs and control state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            bl_p1    <= 6'sd23;
            low_p1   <= 32'h0;
            vld_p1   <= 1'b0;
            nbuf     <= 16'd0;
            bbyte    <= 8'h00;
            emit_val <= 8'h00;
            run_val  <= 8'h00;
            run_cnt  <= 16'd0;
            flushing <= 1'b0;
        end else begin
            state    <= state_nxt;
            bl_p1    <= bl_nxt;
            low_p1   <= low_nxt;
            vld_p1   <= vld_nxt;
            nbuf     <= nbuf_nxt;
            bbyte    <= bbyte_nxt;
            emit_val <= emit_nxt;
            run_val  <= run_val_nxt;
            run_cnt  <= run_cnt_nxt;
            flushing <= flushing_nxt;
        end
    end

    assign bus.bin_ready  = (state == IDLE);
    assign bus.byte_valid = (state == EMIT_BUF) || (state == EMIT_RUN);
    assign bus.byte_data  = (state == EMIT_BUF) ? emit_val : run_val;
    assign bus.flush_done = (state == DONE);
    assign bus.low_out    = low_p1;
    assign bus.low_valid  = vld_p1;
    assign bus.bits_left  = bl_p1;
endmodule

// File: tb/tb_cabac_writeout.sv
// Bench for cabac_writeout: directed scenarios plus random bins/flushes against a byte-queue model.
module tb_cabac_writeout;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cabac_writeout_if bus();
    cabac_writeout dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;

    // Reference model: bit budget, held byte, count of held bytes, bytes owed to the stream.
    int         m_bl;
    int         m_nb;
    logic [7:0] m_bb;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    bit         armed, m_idle, rand_rdy, prev_stall;
    logic [7:0] prev_data;
    logic [31:0] e_low;
    int         e_bl;
    int         done_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_bl = 23; m_nb = 0; m_bb = 8'h00;
        exp_q.delete();
        armed = 0; m_idle = 1; prev_stall = 0;
    endfunction

    function automatic void model_bin(input int nb, input logic [31:0] low);
        int bl_next;
        logic [8:0] lead;
        logic c;
        bl_next = m_bl - nb;
        if (bl_next >= 12) begin
            m_bl  = bl_next;
            e_low = low;
        end else begin
            lead  = 9'((low >> (24 - bl_next)) & 32'h1FF);
            e_low = low & (32'hFFFF_FFFF >> (bl_next + 8));
            m_bl  = bl_next + 8;
            if (lead == 9'h0FF) m_nb++;
            else if (m_nb == 0) begin
                m_bb = lead[7:0]; m_nb = 1;
            end else begin
                c = lead[8];
                exp_q.push_back(m_bb + 8'(c));
                for (int i = 1; i < m_nb; i++) exp_q.push_back(c ? 8'h00 : 8'hFF);
                m_bb = lead[7:0]; m_nb = 1;
            end
        end
        e_bl = m_bl;
    endfunction

    function automatic void model_flush(input logic carry);
        if (m_nb > 0) begin
            exp_q.push_back(m_bb + 8'(carry));
            for (int i = 1; i < m_nb; i++) exp_q.push_back(carry ? 8'h00 : 8'hFF);
        end
        armed = 1;
    endfunction

    // One clock: check the byte handshake, update the model, advance, check registered outputs.
    task automatic cycle();
        bit acc, fl, done;
        if (rand_rdy) bus.byte_ready = ($urandom_range(0, 3) != 0);
        if (prev_stall) begin
            chk("stall_valid", bus.byte_valid, 1);
            chk("stall_data", bus.byte_data, prev_data);
        end
        prev_stall = bus.byte_valid && !bus.byte_ready;
        prev_data  = bus.byte_data;
        if (bus.byte_valid && bus.byte_ready) begin
            got_q.push_back(bus.byte_data);
            if (exp_q.size() == 0) chk("byte_unexpected", bus.byte_valid, 0);
            else chk("byte_data", bus.byte_data, exp_q.pop_front());
        end
        acc = bus.bin_valid && m_idle;
        fl  = bus.flush_req && !bus.bin_valid && m_idle;
        if (acc) model_bin(bus.num_bits, bus.low_in);
        if (fl) model_flush(bus.flush_carry);
        done = armed && (exp_q.size() == 0);
        @(posedge clk); #1;
        chk("low_valid", bus.low_valid, acc);
        if (acc) begin
            chk("low_out", bus.low_out, e_low);
            chk("bits_left", bus.bits_left, 32'(e_bl));
        end
        chk("flush_done", bus.flush_done, done);
        if (bus.flush_done) done_cnt++;
        if (done) begin
            armed = 0; m_nb = 0; m_bb = 8'h00; m_bl = 23;
        end
        m_idle = (exp_q.size() == 0) && !done;
        chk("bin_ready", bus.bin_ready, m_idle);
        chk("byte_valid", bus.byte_valid, exp_q.size() != 0);
    endtask

    task automatic idle_until_ready();
        int n = 0;
        while (!m_idle) begin
            cycle();
            n++;
            if (n > 2000) begin
                chk("idle_timeout", n, 0);
                break;
            end
        end
    endtask

    task automatic send_bin(input int nb, input logic [31:0] low, input bit fl);
        idle_until_ready();
        bus.bin_valid = 1'b1;
        bus.num_bits  = 3'(nb);
        bus.low_in    = low;
        bus.flush_req = fl;
        cycle();
        bus.bin_valid = 1'b0;
        bus.flush_req = 1'b0;
    endtask

    // Bring the budget to 12, then one bit more forces the given lead out of low_in[21:13].
    task automatic send_lead(input logic [8:0] lead);
        idle_until_ready();
        while (m_bl > 12) send_bin((m_bl - 12 > 7) ? 7 : m_bl - 12, $urandom(), 1'b0);
        send_bin(1, {10'($urandom()), lead, 13'($urandom())}, 1'b0);
    endtask

    task automatic do_flush(input bit carry);
        idle_until_ready();
        bus.flush_req   = 1'b1;
        bus.flush_carry = carry;
        cycle();
        bus.flush_req = 1'b0;
        idle_until_ready();
    endtask

    task automatic chk_log(input string tag, input int n, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] c);
        logic [7:0] w[3];
        w = '{a, b, c};
        chk({tag, "_count"}, got_q.size(), n);
        for (int i = 0; i < n && i < got_q.size(); i++) chk(tag, got_q[i], w[i]);
        got_q.delete();
    endtask

    initial begin
        int r, d0;
        bus.bin_valid = 0; bus.num_bits = 0; bus.low_in = 0;
        bus.byte_ready = 1; bus.flush_req = 0; bus.flush_carry = 0;
        rand_rdy = 0;
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_bin_ready", bus.bin_ready, 1);
        chk("rst_byte_valid", bus.byte_valid, 0);
        chk("rst_low_valid", bus.low_valid, 0);
        chk("rst_flush_done", bus.flush_done, 0);
        chk("rst_bits_left", bus.bits_left, 23);
        chk("rst_low_out", bus.low_out, 0);
        rst = 0;
        model_reset();

        // First bins from reset: no lead, then a lead from low_in[21:13].
        send_bin(7, 32'hDEAD_BEEF, 1'b0);
        chk("r031_bl16", bus.bits_left, 16);
        send_bin(5, {10'h3A5, 9'h012, 13'h1ABC}, 1'b0);
        chk("r031_bl19", bus.bits_left, 19);
        chk("r031_low", bus.low_out, 32'h0000_1ABC);

        // 0xFF leads are held until a non-0xFF lead resolves them.
        got_q.delete();
        send_lead(9'h0FF);
        send_lead(9'h0FF);
        chk("r032_nobytes", got_q.size(), 0);
        send_lead(9'h034);
        idle_until_ready();
        chk_log("r032", 3, 8'h12, 8'hFF, 8'hFF);

        // Carry propagation through held 0xFF bytes.
        send_lead(9'h07F);
        idle_until_ready();
        got_q.delete();
        send_lead(9'h0FF);
        send_lead(9'h0FF);
        send_lead(9'h105);
        idle_until_ready();
        chk_log("r033", 3, 8'h80, 8'h00, 8'h00);

        // Back-pressure during the 0xFF run.
        send_lead(9'h0FF);
        send_lead(9'h0FF);
        idle_until_ready();
        got_q.delete();
        send_lead(9'h020);
        cycle();
        bus.byte_ready = 1'b0;
        repeat (5) begin
            cycle();
            chk("r034_bin_ready", bus.bin_ready, 0);
        end
        bus.byte_ready = 1'b1;
        idle_until_ready();
        chk_log("r034", 3, 8'h05, 8'hFF, 8'hFF);

        // Flush with carry over a held 0xFF plus one pending 0xFF.
        send_lead(9'h1FF);
        send_lead(9'h0FF);
        idle_until_ready();
        got_q.delete();
        d0 = done_cnt;
        do_flush(1'b1);
        chk_log("r035", 2, 8'h00, 8'h00, 8'h00);
        chk("r035_done", done_cnt - d0, 1);
        chk("r035_bl23", bus.bits_left, 23);

        // A bin arriving with flush_req wins; the flush is dropped.
        send_lead(9'h044);
        d0 = done_cnt;
        send_bin(3, $urandom(), 1'b1);
        repeat (3) cycle();
        chk("prio_no_done", done_cnt - d0, 0);

        // Reset in the middle of a run discards what is left.
        send_lead(9'h0AA);
        send_lead(9'h0FF);
        send_lead(9'h0FF);
        send_lead(9'h0FF);
        send_lead(9'h011);
        cycle();
        cycle();
        rst = 1'b1;
        bus.byte_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        bus.byte_ready = 1'b1;
        chk("r036_byte_valid", bus.byte_valid, 0);
        chk("r036_bin_ready", bus.bin_ready, 1);
        chk("r036_bits_left", bus.bits_left, 23);
        chk("r036_low_out", bus.low_out, 0);
        model_reset();

        // Flush with nothing held goes straight to the done pulse.
        got_q.delete();
        d0 = done_cnt;
        do_flush(1'b0);
        chk("empty_flush_bytes", got_q.size(), 0);
        chk("empty_flush_done", done_cnt - d0, 1);

        // Random traffic with random back-pressure.
        rand_rdy = 1;
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 19);
            bus.flush_carry = 1'($urandom());
            if (r == 0) do_flush(1'($urandom()));
            else if (r <= 3) send_lead(9'h0FF);
            else if (r == 4) send_lead(9'($urandom()));
            else if (r == 5) cycle();
            else send_bin($urandom_range(0, 7), $urandom(), r == 6);
        end
        do_flush(1'($urandom()));
        idle_until_ready();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
